// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath width and ALU operation encoding
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {ADD, SUB, XOR, OR, AND, NONE} alu_op_t;
endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational 32-bit ALU, results wrap mod 2^32
module ex_alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result
);
  always_comb
    result = op == ADD ? a + b :
             op == SUB ? a - b :
             op == XOR ? a ^ b :
             op == OR  ? a | b :
             op == AND ? a & b : '0;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand loopback, one-cycle registered result and retire counter
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            stall,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            writeback_en_in,
  input  logic            alu_rs2_reg_in,
  input  logic            add_en_in,
  input  logic            sub_en_in,
  input  logic            xor_en_in,
  input  logic            or_en_in,
  input  logic            and_en_in,
  input  logic            rs1_alu_loopback_in,
  input  logic            rs2_alu_loopback_in,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] result_out,
  output logic            writeback_en_out,
  output logic            valid_out,
  output logic            op_err,
  output logic [31:0]     retire_count
);
  logic [4:0]      sel;
  alu_op_t         op;
  logic [XLEN-1:0] a, b, res;
  always_comb begin
    sel = {add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in};
    op  = add_en_in ? ADD : sub_en_in ? SUB : xor_en_in ? XOR : or_en_in ? OR : and_en_in ? AND : NONE;
    a   = rs1_alu_loopback_in ? result_out : rs1_in;
    b   = !alu_rs2_reg_in ? imm_in : rs2_alu_loopback_in ? result_out : rs2_in;
  end
  ex_alu u_alu (.a(a), .b(b), .op(op), .result(res));
  always_ff @(posedge clk)
    if (!rst) begin
      rd_addr_out      <= '0;
      result_out       <= '0;
      writeback_en_out <= 1'b0;
      valid_out        <= 1'b0;
      op_err           <= 1'b0;
      retire_count     <= '0;
    end else if (!stall) begin
      valid_out        <= valid_in;
      writeback_en_out <= valid_in && writeback_en_in && rd_addr_in != 5'd0;
      if (valid_in) begin
        result_out   <= res;
        rd_addr_out  <= rd_addr_in;
        op_err       <= op_err | !$onehot(sel);
        retire_count <= retire_count + 32'd1;
      end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector checks of ex_stage
module tb_ex_stage;
  logic        clk = 0, rst = 0, valid_in = 0, stall = 0, writeback_en_in = 0, alu_rs2_reg_in = 0;
  logic        add_en_in = 0, sub_en_in = 0, xor_en_in = 0, or_en_in = 0, and_en_in = 0;
  logic        rs1_alu_loopback_in = 0, rs2_alu_loopback_in = 0;
  logic [4:0]  rd_addr_in = 0, rd_addr_out;
  logic [31:0] rs1_in = 0, rs2_in = 0, imm_in = 0, result_out, retire_count;
  logic        writeback_en_out, valid_out, op_err;
  logic [31:0] exp_cnt;
  int          tests = 0, fails = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .rd_addr_in(rd_addr_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in), .writeback_en_in(writeback_en_in),
    .alu_rs2_reg_in(alu_rs2_reg_in), .add_en_in(add_en_in), .sub_en_in(sub_en_in),
    .xor_en_in(xor_en_in), .or_en_in(or_en_in), .and_en_in(and_en_in),
    .rs1_alu_loopback_in(rs1_alu_loopback_in), .rs2_alu_loopback_in(rs2_alu_loopback_in),
    .rd_addr_out(rd_addr_out), .result_out(result_out), .writeback_en_out(writeback_en_out),
    .valid_out(valid_out), .op_err(op_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  // sel bit order: add, sub, xor, or, and
  task automatic set_in(input logic [4:0] sel, input logic [31:0] a, bv, imm, input logic r2, l1, l2,
                        input logic [4:0] rd, input logic wb);
    {add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in} = sel;
    rs1_in = a; rs2_in = bv; imm_in = imm; alu_rs2_reg_in = r2;
    rs1_alu_loopback_in = l1; rs2_alu_loopback_in = l2; rd_addr_in = rd; writeback_en_in = wb;
  endtask

  task automatic issue(input logic [4:0] sel, input logic [31:0] a, bv, imm, input logic r2, l1, l2,
                       input logic [4:0] rd, input logic wb);
    set_in(sel, a, bv, imm, r2, l1, l2, rd, wb);
    valid_in = 1; stall = 0;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic test_reset;
    rst = 0; valid_in = 1; stall = 1;
    set_in(5'b10000, 32'd1, 32'd1, 32'd1, 0, 0, 0, 5'd4, 1);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count} !== 72'd0) begin
      fails++; $display("FAIL reset: res=%h rd=%0d wb=%b v=%b err=%b cnt=%h required all 0",
                        result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count);
    end
    rst = 1; stall = 0; valid_in = 0; exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_imm;
    issue(5'b10000, 32'd5, 32'd99, 32'd7, 0, 0, 0, 5'd3, 1);
    tests++;
    if (result_out !== 32'd12) begin fails++; $display("FAIL add_imm result: got %0d want 12", result_out); end
    tests++;
    if ({rd_addr_out, writeback_en_out, valid_out} !== {5'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL add_imm ctl: rd=%0d wb=%b v=%b want 3 1 1", rd_addr_out, writeback_en_out, valid_out);
    end
    tests++;
    if (retire_count !== 32'd1) begin fails++; $display("FAIL add_imm count: got %0d want 1", retire_count); end
  endtask

  task automatic test_back_to_back;
    issue(5'b01000, 32'd10, 32'd3, 32'd0, 1, 0, 0, 5'd1, 1);
    tests++;
    if (result_out !== 32'd7) begin fails++; $display("FAIL b2b sub: got %0d want 7", result_out); end
    issue(5'b10000, 32'd100, 32'd1, 32'd50, 1, 1, 0, 5'd2, 1);
    tests++;
    if (result_out !== 32'd8) begin fails++; $display("FAIL b2b add_loop: got %0d want 8", result_out); end
    issue(5'b10000, 32'd3, 32'd100, 32'd0, 1, 0, 1, 5'd2, 1);
    tests++;
    if (result_out !== 32'd11) begin fails++; $display("FAIL b2b rs2_loop: got %0d want 11", result_out); end
  endtask

  task automatic test_rs2_loop_imm;
    issue(5'b10000, 32'd9, 32'd0, 32'd0, 0, 0, 0, 5'd7, 1);
    issue(5'b10000, 32'd1, 32'd50, 32'd4, 0, 0, 1, 5'd7, 1);
    tests++;
    if (result_out !== 32'd5) begin fails++; $display("FAIL rs2_loop_imm: got %0d want 5", result_out); end
  endtask

  task automatic test_bubble;
    valid_in = 0; stall = 0;
    set_in(5'b10000, 32'd40, 32'd40, 32'd40, 0, 0, 0, 5'd9, 1);
    @(posedge clk); #1;
    tests++;
    if ({result_out, rd_addr_out, writeback_en_out, valid_out, retire_count} !== {32'd5, 5'd7, 1'b0, 1'b0, exp_cnt}) begin
      fails++; $display("FAIL bubble: res=%0d rd=%0d wb=%b v=%b cnt=%0d want 5 7 0 0 %0d",
                        result_out, rd_addr_out, writeback_en_out, valid_out, retire_count, exp_cnt);
    end
  endtask

  task automatic test_rd_zero_stall;
    issue(5'b10000, 32'd2, 32'd0, 32'd2, 0, 0, 0, 5'd0, 1);
    tests++;
    if ({result_out, rd_addr_out, writeback_en_out, valid_out} !== {32'd4, 5'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL rd_zero: res=%0d rd=%0d wb=%b v=%b want 4 0 0 1",
                        result_out, rd_addr_out, writeback_en_out, valid_out);
    end
    stall = 1; valid_in = 1;
    set_in(5'b00000, 32'd77, 32'd77, 32'd77, 1, 0, 0, 5'd12, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count} !==
          {32'd4, 5'd0, 1'b0, 1'b1, 1'b0, exp_cnt}) begin
        fails++; $display("FAIL stall cycle %0d: res=%0d rd=%0d wb=%b v=%b err=%b cnt=%0d want 4 0 0 1 0 %0d",
                          i, result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count, exp_cnt);
      end
    end
    stall = 0;
  endtask

  task automatic test_ops;
    logic [4:0]  sel [5]  = '{5'b00100, 5'b00010, 5'b00001, 5'b01000, 5'b10000};
    logic [31:0] a   [5]  = '{32'd6, 32'd6, 32'd6, 32'd0, 32'hFFFFFFFF};
    logic [31:0] bv  [5]  = '{32'd3, 32'd3, 32'd3, 32'd1, 32'd2};
    logic [31:0] want [5] = '{32'd5, 32'd7, 32'd2, 32'hFFFFFFFF, 32'd1};
    for (int i = 0; i < 5; i++) begin
      issue(sel[i], a[i], bv[i], 32'd0, 1, 0, 0, 5'd5, 1);
      tests++;
      if (result_out !== want[i]) begin
        fails++; $display("FAIL op %0d: got %h want %h", i, result_out, want[i]);
      end
    end
    tests++;
    if (op_err !== 1'b0 || retire_count !== exp_cnt) begin
      fails++; $display("FAIL ops status: err=%b cnt=%0d want 0 %0d", op_err, retire_count, exp_cnt);
    end
  endtask

  task automatic test_multi_hot;
    issue(5'b10100, 32'd6, 32'd3, 32'd0, 1, 0, 0, 5'd6, 1);
    tests++;
    if (result_out !== 32'd9 || op_err !== 1'b1) begin
      fails++; $display("FAIL multi_hot add_xor: res=%0d err=%b want 9 1", result_out, op_err);
    end
    issue(5'b01001, 32'd6, 32'd3, 32'd0, 1, 0, 0, 5'd6, 1);
    tests++;
    if (result_out !== 32'd3) begin fails++; $display("FAIL multi_hot sub_and: got %0d want 3", result_out); end
    issue(5'b00011, 32'd6, 32'd3, 32'd0, 1, 0, 0, 5'd6, 1);
    tests++;
    if (result_out !== 32'd7) begin fails++; $display("FAIL multi_hot or_and: got %0d want 7", result_out); end
    issue(5'b00000, 32'd6, 32'd3, 32'd0, 1, 0, 0, 5'd6, 1);
    tests++;
    if (result_out !== 32'd0 || op_err !== 1'b1) begin
      fails++; $display("FAIL zero_hot: res=%0d err=%b want 0 1", result_out, op_err);
    end
    issue(5'b10000, 32'd1, 32'd1, 32'd0, 1, 0, 0, 5'd6, 1);
    tests++;
    if (op_err !== 1'b1) begin fails++; $display("FAIL op_err sticky: got %b want 1", op_err); end
  endtask

  task automatic test_wrap;
    force dut.retire_count = 32'hFFFFFFFF;
    #1;
    release dut.retire_count;
    exp_cnt = 32'hFFFFFFFF;
    issue(5'b10000, 32'd1, 32'd0, 32'd1, 0, 0, 0, 5'd8, 1);
    tests++;
    if (retire_count !== 32'd0 || exp_cnt !== 32'd0) begin
      fails++; $display("FAIL count_wrap: got %h want 00000000", retire_count);
    end
  endtask

  task automatic test_reset_midstream;
    set_in(5'b10000, 32'd20, 32'd0, 32'd22, 0, 0, 0, 5'd9, 1);
    valid_in = 1; rst = 0;
    @(posedge clk); #1;
    tests++;
    if ({result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count} !== 72'd0) begin
      fails++; $display("FAIL reset_mid: res=%h rd=%0d wb=%b v=%b err=%b cnt=%h required all 0",
                        result_out, rd_addr_out, writeback_en_out, valid_out, op_err, retire_count);
    end
    rst = 1; valid_in = 0;
  endtask

  initial begin
    exp_cnt = 0;
    @(negedge clk);
    test_reset;
    test_add_imm;
    test_back_to_back;
    test_rs2_loop_imm;
    test_bubble;
    test_rd_zero_stall;
    test_ops;
    test_multi_hot;
    test_wrap;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
